// File: rtl/r_resp_gen.sv
// r_resp_gen: slave-side AXI read responder.
// AR requests are queued in order. Each beat is fetched from a synchronous memory port
// (data returns the cycle after mem_re) and then presented on the R channel with VALID/READY.
// Optional macro R_RANGE_CHECK_EN: beats at or above ADDR_LIMIT skip the memory read and
// return RDATA=0 with RRESP=SLVERR; the burst still runs to RLAST.
module r_resp_gen #(
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           CMD_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(CMD_DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND} state_e;

  state_e state_q, state_d;

  cmd_t             cmd_q [CMD_DEPTH];
  cmd_t             head_c;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             arready_q;
  logic             push_c, pop_c;

  logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d, oob_c;

  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

`ifndef R_RANGE_CHECK_EN
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
`endif

  assign push_c  = ARVALID & arready_q;
  assign pop_c   = (state_q == S_IDLE) && (count_q != '0);
  assign head_c  = cmd_q[rd_ptr_q];
  assign count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RID      = rid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign RLAST    = rlast_q;
  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;

  // Command queue storage (payload only, no reset needed)
  always_ff @(posedge ACLK) begin
    if (push_c) begin
      cmd_q[wr_ptr_q] <= '{id: ARID, addr: ARADDR, len: ARLEN};
    end
  end

  // Command queue pointers, occupancy and registered ARREADY
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      arready_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      arready_q <= (count_d != CNT_W'(CMD_DEPTH));
    end
  end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (RREADY) state_d = rlast_q ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output / datapath next values
  always_comb begin
    cur_id_d   = cur_id_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          cur_id_d   = head_c.id;
          cur_addr_d = head_c.addr;
          beat_cnt_d = head_c.len;
        end
      end
      S_LOAD: begin
        rvalid_d = 1'b1;
        rid_d    = cur_id_q;
        rdata_d  = err_q ? '0 : mem_rdata;
        rresp_d  = err_q ? 2'b10 : 2'b00;
        rlast_d  = (beat_cnt_q == 8'd0);
      end
      S_SEND: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          if (!rlast_q) begin
            beat_cnt_d = beat_cnt_q - 8'd1;
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(BEAT_BYTES);
          end
        end
      end
      default: ;
    endcase
`ifdef R_RANGE_CHECK_EN
    oob_c = (cur_addr_d >= ADDR_LIMIT);
`else
    oob_c = 1'b0;
`endif
    mem_re_d   = (state_d == S_FETCH) && !oob_c;
    mem_addr_d = (state_d == S_FETCH) ? cur_addr_d : mem_addr_q;
    err_d      = (state_d == S_FETCH) ? oob_c : err_q;
  end

  // Datapath and R channel output registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_id_q   <= '0;
      cur_addr_q <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rlast_q    <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      cur_id_q   <= cur_id_d;
      cur_addr_q <= cur_addr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule
